// File: rtl/mem_wb_stage_pkg.sv
// Shared constants and types for the MEM/WB stage.
// Load funct3 encodings match the core decoder.
// The WB entry struct is the full registered writeback request.
package mem_wb_stage_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef struct packed {
    logic        reg_write;
    logic [4:0]  rd;
    logic [31:0] data;
    logic        misaligned;
  } wb_entry_t;

endpackage

// File: rtl/mem_wb_stage_load_align.sv
// Purpose: extract and extend a byte/halfword/word from the memory read word.
// Latency: purely combinational.
// Backpressure: none; the caller registers the result.
module load_align
  import mem_wb_stage_pkg::*;
(
  input  logic [31:0] i_mem_read,
  input  logic [1:0]  i_off,
  input  logic [2:0]  i_funct3,
  output logic [31:0] o_data,
  output logic        o_misaligned
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Select the addressed byte and halfword lanes from the read word
  always_comb begin
    w_byte = 8'h00;
    case (i_off)
      2'd0: w_byte = i_mem_read[7:0];
      2'd1: w_byte = i_mem_read[15:8];
      2'd2: w_byte = i_mem_read[23:16];
      2'd3: w_byte = i_mem_read[31:24];
      default: w_byte = 8'h00;
    endcase
    w_half = i_off[1] ? i_mem_read[31:16] : i_mem_read[15:0];
  end

  // Extend per load width/sign; a misaligned access always yields zero data
  always_comb begin
    o_data       = 32'h0;
    o_misaligned = 1'b0;
    case (i_funct3)
      F3_LB:  o_data = {{24{w_byte[7]}}, w_byte};
      F3_LBU: o_data = {24'h0, w_byte};
      F3_LH: begin
        o_misaligned = i_off[0];
        o_data       = i_off[0] ? 32'h0 : {{16{w_half[15]}}, w_half};
      end
      F3_LHU: begin
        o_misaligned = i_off[0];
        o_data       = i_off[0] ? 32'h0 : {16'h0, w_half};
      end
      F3_LW: begin
        o_misaligned = (i_off != 2'd0);
        o_data       = (i_off != 2'd0) ? 32'h0 : i_mem_read;
      end
      default: o_data = 32'h0;
    endcase
  end

endmodule

// File: rtl/mem_wb_stage.sv
// Purpose: MEM/WB pipeline register, writeback-data select and retired counter.
// Latency: 1 cycle from MEM-side inputs to registered wb_* outputs.
// Backpressure: stall holds the entry and counter; flush inserts a bubble.
module mem_wb_stage
  import mem_wb_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic        mem_valid,
  input  logic        mem_regWrite,
  input  logic        mem_memToReg,
  input  logic        mem_jump,
  input  logic [2:0]  mem_funct3,
  input  logic [4:0]  mem_rd,
  input  logic [31:0] mem_aluResult,
  input  logic [31:0] mem_pcPlus4,
  input  logic [31:0] MemRead,
  output logic        wb_regWrite,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        wb_misaligned,
  output logic [31:0] retired
);

  logic [31:0] w_align_data;
  logic        w_align_mis;
  logic        w_load_mis;
  wb_entry_t   w_next;
  wb_entry_t   r_wb;
  logic [31:0] r_retired;

  load_align u_load_align (
    .i_mem_read   (MemRead),
    .i_off        (mem_aluResult[1:0]),
    .i_funct3     (mem_funct3),
    .o_data       (w_align_data),
    .o_misaligned (w_align_mis)
  );

  // Build the next WB entry from MEM-side inputs: jump > load > ALU
  always_comb begin
    w_load_mis        = mem_valid & mem_memToReg & w_align_mis;
    w_next            = '0;
    w_next.misaligned = w_load_mis;
    w_next.rd         = mem_valid ? mem_rd : 5'd0;
    w_next.reg_write  = mem_valid & mem_regWrite & (mem_rd != 5'd0) & ~w_load_mis;
    if (w_load_mis)
      w_next.data = 32'h0;
    else if (mem_jump)
      w_next.data = mem_pcPlus4;
    else if (mem_memToReg)
      w_next.data = w_align_data;
    else
      w_next.data = mem_aluResult;
  end

  // WB register and retired counter: reset > flush > stall > capture
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wb      <= '0;
      r_retired <= 32'h0;
    end else if (flush) begin
      r_wb      <= '0;
    end else if (!stall) begin
      r_wb      <= w_next;
      if (mem_valid)
        r_retired <= r_retired + 32'd1;
    end
  end

  assign wb_regWrite   = r_wb.reg_write;
  assign wb_rd         = r_wb.rd;
  assign wb_data       = r_wb.data;
  assign wb_misaligned = r_wb.misaligned;
  assign retired       = r_retired;

endmodule
